// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_seq_pkg;

   localparam int WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      CALC,
      FIN
   } state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencer for mul_seq: walks IDLE -> LOAD_A -> LOAD_B -> CALC* -> FIN and
// emits one-hot datapath strobes.
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int EARLY_TERM = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic mplr_zero,
   input  logic cnt_end,
   output logic accept,
   output logic load_a,
   output logic load_b,
   output logic calc,
   output logic fin,
   output logic busy
);

   state_t state, state_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load_a    = 1'b0;
      load_b    = 1'b0;
      calc      = 1'b0;
      fin       = 1'b0;
      busy      = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = LOAD_A;
            end
         end
         LOAD_A: begin
            load_a    = 1'b1;
            state_nxt = LOAD_B;
         end
         LOAD_B: begin
            load_b    = 1'b1;
            state_nxt = CALC;
         end
         CALC: begin
            calc = 1'b1;
            // mplr_zero looks at the multiplier as it will be after this shift
            if (cnt_end || ((EARLY_TERM != 0) && mplr_zero))
               state_nxt = FIN;
         end
         FIN: begin
            fin       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: magnitude datapath with sign fix-up in FIN,
// operands streamed over a shared data_in bus.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int EARLY_TERM = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   data_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic               accept, load_a, load_b, calc, fin;
   logic               smode, sign_a, neg, sign_in;
   logic [WIDTH-1:0]   mplr, mag;
   logic [2*WIDTH-1:0] mcand, acc;
   logic [CW-1:0]      cnt;
   logic               mplr_zero, cnt_end;

   // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude
   assign sign_in   = data_in[WIDTH-1] & smode;
   assign mag       = sign_in ? -data_in : data_in;
   assign mplr_zero = (mplr[WIDTH-1:1] == '0);
   assign cnt_end   = (cnt == CW'(WIDTH - 1));

   mul_seq_ctrl #(.EARLY_TERM(EARLY_TERM)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mplr_zero (mplr_zero),
      .cnt_end   (cnt_end),
      .accept    (accept),
      .load_a    (load_a),
      .load_b    (load_b),
      .calc      (calc),
      .fin       (fin),
      .busy      (busy)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         smode   <= 1'b0;
         sign_a  <= 1'b0;
         neg     <= 1'b0;
         mplr    <= '0;
         mcand   <= '0;
         acc     <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         if (accept) begin
            smode <= signed_mode;
            done  <= 1'b0;
         end
         if (load_a) begin
            mcand  <= {{WIDTH{1'b0}}, mag};
            sign_a <= sign_in;
         end
         if (load_b) begin
            mplr <= mag;
            neg  <= sign_a ^ sign_in;
            acc  <= '0;
            cnt  <= '0;
         end
         if (calc) begin
            if (mplr[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
         end
         if (fin) begin
            // negating a zero accumulator yields zero, so no -0 can appear
            product <= neg ? -acc : acc;
            done    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboarded bench for mul_seq: early-terminating and fixed-latency instances.
module tb_mul_seq;

   localparam int W = 16;

   typedef struct {
      logic [2*W-1:0] prod;
      int             lat;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst, start, signed_mode;
   logic [W-1:0]   data_in;
   logic           busy, done;
   logic [2*W-1:0] product;
   logic           start_f, signed_mode_f;
   logic [W-1:0]   data_in_f;
   logic           busy_f, done_f;
   logic [2*W-1:0] product_f;

   exp_t           sb_q[$];
   int             vectors = 0;
   int             miscompares = 0;
   logic [2*W-1:0] last_prod = '0;

   always #5 clk = ~clk;

   mul_seq #(.WIDTH(W), .EARLY_TERM(1)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .data_in(data_in), .busy(busy), .done(done), .product(product)
   );

   mul_seq #(.WIDTH(W), .EARLY_TERM(0)) dut_f (
      .clk(clk), .rst(rst), .start(start_f), .signed_mode(signed_mode_f),
      .data_in(data_in_f), .busy(busy_f), .done(done_f), .product(product_f)
   );

   function automatic logic [2*W-1:0] model_prod(input logic sm, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
      longint sa, sb, p;
      if (sm) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      p = sa * sb;
      return p[2*W-1:0];
   endfunction

   function automatic int model_lat(input logic sm, input logic [W-1:0] b, input bit early);
      logic [W:0] m;
      int n;
      if (!early) return 3 + W;
      m = (sm && b[W-1]) ? (17'h10000 - {1'b0, b}) : {1'b0, b};
      n = 0;
      for (int i = 0; i <= W; i++) if (m[i]) n = i + 1;
      if (n < 1) n = 1;
      return 3 + n;
   endfunction

   // start at edge k, A at k+1, B at k+2; returns at the negedge after k+2
   task automatic drive_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit hold);
      @(negedge clk);
      start = 1'b1; signed_mode = sm; data_in = W'($urandom);
      @(negedge clk);
      start = hold; signed_mode = ~sm; data_in = a;
      @(negedge clk);
      data_in = b;
      @(negedge clk);
      data_in = W'($urandom);
   endtask

   task automatic collect(input string name);
      int   edges = 2;
      bit   got = 0;
      exp_t e;
      repeat (60) begin
         @(posedge clk); edges++; #1;
         if (done) begin got = 1; break; end
      end
      e = sb_q.pop_front();
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL %s timeout: done never rose, required at edge +%0d", name, e.lat);
      end else begin
         if (product !== e.prod) begin
            miscompares++;
            $display("FAIL %s product: got %h required %h", name, product, e.prod);
         end
         vectors++;
         if (edges != e.lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required %0d", name, edges, e.lat);
         end
      end
      last_prod = e.prod;
   endtask

   task automatic issue(input string name, input logic sm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp_prod);
      sb_q.push_back('{prod: exp_prod, lat: model_lat(sm, b, 1)});
      drive_op(sm, a, b, 0);
      vectors++;
      if (product !== last_prod || done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s hold: got product %h done %b required %h 0", name, product,
                  done, last_prod);
      end
      collect(name);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; signed_mode = 1'b0; data_in = '0;
      start_f = 1'b0; signed_mode_f = 1'b0; data_in_f = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         miscompares++;
         $display("FAIL reset: got busy %b done %b product %h required 0 0 0", busy, done,
                  product);
      end
      @(negedge clk); rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_prio: got busy %b required 0", busy);
      end
   endtask

   task automatic test_basic();
      issue("u17x5", 1'b0, 16'd17, 16'd5, 32'd85);
      issue("s-3x7", 1'b1, 16'hFFFD, 16'd7, 32'hFFFFFFEB);
      issue("smin2", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
      issue("umax2", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
   endtask

   task automatic test_zero();
      issue("zeroB", 1'b0, 16'd1234, 16'd0, 32'd0);
      issue("s-5x0", 1'b1, 16'hFFFB, 16'd0, 32'd0);
      issue("s0x-7", 1'b1, 16'd0, 16'hFFF9, 32'd0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         logic         sm;
         logic [W-1:0] a, b;
         sm = 1'($urandom);
         a  = W'($urandom);
         b  = W'($urandom);
         if (i == 0) b = 16'h8000;
         if (i == 1) b = 16'd1;
         issue("rand", sm, a, b, model_prod(sm, a, b));
      end
   endtask

   task automatic test_fixed_latency();
      int   edges = 2;
      bit   got = 0;
      exp_t e;
      sb_q.push_back('{prod: 32'd85, lat: model_lat(1'b0, 16'd5, 0)});
      @(negedge clk); start_f = 1'b1; signed_mode_f = 1'b0;
      @(negedge clk); start_f = 1'b0; data_in_f = 16'd17;
      @(negedge clk); data_in_f = 16'd5;
      @(negedge clk); data_in_f = '0;
      repeat (60) begin
         @(posedge clk); edges++; #1;
         if (done_f) begin got = 1; break; end
      end
      e = sb_q.pop_front();
      vectors++;
      if (!got || product_f !== e.prod || edges != e.lat) begin
         miscompares++;
         $display("FAIL fixed17x5: got done %b product %h edge +%0d required %h at +%0d",
                  got, product_f, edges, e.prod, e.lat);
      end
   endtask

   task automatic test_reset_mid();
      drive_op(1'b0, 16'd1000, 16'd1000, 0);
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: got busy %b done %b product %h required 0 0 0", busy,
                  done, product);
      end
      @(negedge clk); rst = 1'b0;
      last_prod = '0;
      issue("post_rst6x7", 1'b0, 16'd6, 16'd7, 32'd42);
   endtask

   task automatic test_start_held();
      sb_q.push_back('{prod: 32'd391, lat: model_lat(1'b0, 16'd17, 1)});
      drive_op(1'b0, 16'd23, 16'd17, 1);
      collect("held23x17");
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL held_idle: got busy %b required 0", busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL held_restart: got done %b busy %b required 0 1", done, busy);
      end
      @(negedge clk); start = 1'b0; data_in = 16'd6;
      @(negedge clk); data_in = 16'd7;
      @(negedge clk); data_in = '0;
      sb_q.push_back('{prod: 32'd42, lat: model_lat(1'b0, 16'd7, 1)});
      collect("held_next6x7");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_back_to_back();
      test_fixed_latency();
      test_reset_mid();
      test_start_held();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
